// File: rtl/wired_cdb_arbiter_pkg.sv
// Shared types and helpers for the CDB write-back arbiter.
package wired_cdb_arbiter_pkg;

  localparam int CDB_PORT_COUNT = 2;

  typedef logic [4:0] rob_rid_t;

  typedef struct packed {
    rob_rid_t    rob_id;
    logic [31:0] wdata;
    logic        excp;
    logic [5:0]  ecode;
  } cdb_req_t;

  // Increment an index modulo n, with an explicit wrap so that a
  // non-power-of-two n never yields an out-of-range index.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wired_cdb_arbiter_if.sv
// Requester handshake and CDB result bus between the functional units and the arbiter.
interface wired_cdb_arbiter_if #(
  parameter int REQ_COUNT = 4
);
  import wired_cdb_arbiter_pkg::*;

  logic [REQ_COUNT-1:0]                 req_valid_i;
  logic [REQ_COUNT-1:0]                 req_ready_o;
  cdb_req_t [REQ_COUNT-1:0]             req_i;
  logic [CDB_PORT_COUNT-1:0]            cdb_valid_o;
  cdb_req_t [CDB_PORT_COUNT-1:0]        cdb_o;

  // Requester / consumer side.
  modport master (
    output req_valid_i,
    output req_i,
    input  req_ready_o,
    input  cdb_valid_o,
    input  cdb_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid_i,
    input  req_i,
    output req_ready_o,
    output cdb_valid_o,
    output cdb_o
  );

endinterface

// File: rtl/wired_rr_pick.sv
// Circular first-one finder: lowest set bit of mask at or after start, wrapping.
module wired_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, start} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (mask[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the registered CDB.
module wired_cdb_arbiter
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  wired_cdb_arbiter_if.slave   bus,
  output logic [CNT_WIDTH-1:0] conflict_cnt_o
);

  localparam int PTR_W = $clog2(REQ_COUNT);

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     a_idx;
  logic [PTR_W-1:0]     b_idx;
  logic [PTR_W-1:0]     b_start;
  logic [REQ_COUNT-1:0] b_mask;
  logic                 a_found;
  logic                 b_found;
  logic                 grant_a;
  logic                 grant_b;
  logic                 conflict;

  wired_rr_pick #(.N(REQ_COUNT)) u_pick_a (
    .mask  (bus.req_valid_i),
    .start (ptr),
    .found (a_found),
    .idx   (a_idx)
  );

  // Second winner searches from just past A, with A removed from the mask.
  always_comb begin
    b_start = PTR_W'(wrap_inc(32'(a_idx), REQ_COUNT));
    b_mask  = bus.req_valid_i;
    b_mask[a_idx] = 1'b0;
  end

  wired_rr_pick #(.N(REQ_COUNT)) u_pick_b (
    .mask  (b_mask),
    .start (b_start),
    .found (b_found),
    .idx   (b_idx)
  );

  assign grant_a  = a_found & ~flush_i;
  assign grant_b  = b_found & ~flush_i;
  assign conflict = !flush_i &&
                    ($countones(bus.req_valid_i) > (int'(grant_a) + int'(grant_b)));

  // Ready is purely combinational from valid, pointer and flush; payload plays no part.
  always_comb begin
    bus.req_ready_o = '0;
    if (grant_a) bus.req_ready_o[a_idx] = 1'b1;
    if (grant_b) bus.req_ready_o[b_idx] = 1'b1;
  end

  // CDB output stage and pointer advance; a flush leaves no grants, so valids drop and ptr holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr             <= '0;
      bus.cdb_valid_o <= '0;
      bus.cdb_o       <= '0;
    end else begin
      bus.cdb_valid_o <= {grant_b, grant_a};
      if (grant_a) bus.cdb_o[0] <= bus.req_i[a_idx];
      if (grant_b) bus.cdb_o[1] <= bus.req_i[b_idx];
      if (grant_b) begin
        ptr <= PTR_W'(wrap_inc(32'(b_idx), REQ_COUNT));
      end else if (grant_a) begin
        ptr <= PTR_W'(wrap_inc(32'(a_idx), REQ_COUNT));
      end
    end
  end

  // Saturating count of cycles where a valid request was left waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != {CNT_WIDTH{1'b1}})) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Randomised and directed bench for the CDB arbiter against a behavioural model.
module tb_wired_cdb_arbiter;
  import wired_cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        flush  = 1'b0;
  logic        chk_en = 1'b0;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  int          checks = 0;
  int          errors = 0;

  cdb_req_t cur  [N];
  cdb_req_t prev [N];

  // Model state.
  int          m_ptr;
  logic [1:0]  m_valid;
  cdb_req_t    m_cdb [2];
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  wired_cdb_arbiter_if #(.REQ_COUNT(N)) bus ();
  wired_cdb_arbiter_if #(.REQ_COUNT(N)) bus2 ();

  assign bus2.req_valid_i = bus.req_valid_i;
  assign bus2.req_i       = bus.req_i;

  wired_cdb_arbiter #(.REQ_COUNT(N), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .bus            (bus),
    .conflict_cnt_o (cnt)
  );

  wired_cdb_arbiter #(.REQ_COUNT(N), .CNT_WIDTH(2)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .bus            (bus2),
    .conflict_cnt_o (cnt2)
  );

  always #5 clk = ~clk;

  // nth (0 or 1) valid requester met when walking circularly from p, or -1.
  function automatic int pick(input logic [N-1:0] v, input int p, input int nth);
    int seen = 0;
    for (int k = 0; k < N; k++) begin
      int j = (p + k) % N;
      if (v[j]) begin
        if (seen == nth) return j;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v, input int p, input logic fl);
    logic [N-1:0] r = '0;
    if (!fl) begin
      for (int n = 0; n < 2; n++) begin
        int w = pick(v, p, n);
        if (w >= 0) r[w] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic cdb_req_t rand_req();
    cdb_req_t r;
    r.rob_id = 5'($urandom);
    r.wdata  = $urandom;
    r.excp   = 1'($urandom);
    r.ecode  = 6'($urandom);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Behavioural model: two lowest-order winners in circular order, pointer past the last winner.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr   <= 0;
      m_valid <= 2'b00;
      m_cdb[0] <= '0;
      m_cdb[1] <= '0;
      m_cnt   <= '0;
      m_cnt2  <= '0;
    end else if (flush) begin
      m_valid <= 2'b00;
    end else begin
      m_valid <= {pick(bus.req_valid_i, m_ptr, 1) >= 0, pick(bus.req_valid_i, m_ptr, 0) >= 0};
      if (pick(bus.req_valid_i, m_ptr, 0) >= 0) m_cdb[0] <= bus.req_i[pick(bus.req_valid_i, m_ptr, 0)];
      if (pick(bus.req_valid_i, m_ptr, 1) >= 0) m_cdb[1] <= bus.req_i[pick(bus.req_valid_i, m_ptr, 1)];
      if (pick(bus.req_valid_i, m_ptr, 1) >= 0)
        m_ptr <= (pick(bus.req_valid_i, m_ptr, 1) + 1) % N;
      else if (pick(bus.req_valid_i, m_ptr, 0) >= 0)
        m_ptr <= (pick(bus.req_valid_i, m_ptr, 0) + 1) % N;
      // At most two grants per cycle, so anything beyond two valids is a conflict.
      if ($countones(bus.req_valid_i) > 2) begin
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        if (m_cnt2 != 2'b11) m_cnt2 <= m_cnt2 + 2'd1;
      end
    end
  end

  // Compare process: inputs are stable here and registered outputs reflect the last edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready", 64'(bus.req_ready_o), 64'(exp_ready(bus.req_valid_i, m_ptr, flush)));
      chk("model_cdb_valid", 64'(bus.cdb_valid_o), 64'(m_valid));
      if (m_valid[0]) chk("model_cdb0", 64'(bus.cdb_o[0]), 64'(m_cdb[0]));
      if (m_valid[1]) chk("model_cdb1", 64'(bus.cdb_o[1]), 64'(m_cdb[1]));
      chk("model_cnt", 64'(cnt), 64'(m_cnt));
      chk("model_cnt_sat", 64'(cnt2), 64'(m_cnt2));
      chk("model_sat_cdb_valid", 64'(bus2.cdb_valid_o), 64'(m_valid));
    end
  end

  task automatic step(input logic [N-1:0] v, input logic fl);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      prev[i] = cur[i];
      cur[i]  = rand_req();
      bus.req_i[i] = cur[i];
    end
    bus.req_valid_i = v;
    flush = fl;
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cur[i] = '0;
      prev[i] = '0;
    end
    bus.req_valid_i = '0;
    bus.req_i       = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_cdb_valid", 64'(bus.cdb_valid_o), 64'd0);
    chk("reset_cnt", 64'(cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Full contention: pairs {0,1},{2,3},{0,1},{2,3}.
    step(4'b1111, 1'b0);
    chk("cont1_ready", 64'(bus.req_ready_o), 64'b0011);
    step(4'b1111, 1'b0);
    chk("cont2_ready", 64'(bus.req_ready_o), 64'b1100);
    chk("cont2_cdb_valid", 64'(bus.cdb_valid_o), 64'b11);
    chk("cont2_cdb0", 64'(bus.cdb_o[0]), 64'(prev[0]));
    chk("cont2_cdb1", 64'(bus.cdb_o[1]), 64'(prev[1]));
    step(4'b1111, 1'b0);
    chk("cont3_ready", 64'(bus.req_ready_o), 64'b0011);
    chk("cont3_cdb0", 64'(bus.cdb_o[0]), 64'(prev[2]));
    chk("cont3_cdb1", 64'(bus.cdb_o[1]), 64'(prev[3]));
    step(4'b1111, 1'b0);
    chk("cont4_ready", 64'(bus.req_ready_o), 64'b1100);
    step(4'b0000, 1'b0);
    chk("cont_cnt", 64'(cnt), 64'd4);
    chk("cont_cnt_sat", 64'(cnt2), 64'd3);
    chk("cont_cdb0", 64'(bus.cdb_o[0]), 64'(prev[2]));
    chk("cont_cdb1", 64'(bus.cdb_o[1]), 64'(prev[3]));

    // Single requester, then wrap from ptr 3.
    step(4'b0100, 1'b0);
    chk("single_ready", 64'(bus.req_ready_o), 64'b0100);
    chk("idle_cdb_valid", 64'(bus.cdb_valid_o), 64'b00);
    step(4'b1001, 1'b0);
    chk("single_cdb_valid", 64'(bus.cdb_valid_o), 64'b01);
    chk("single_cdb0", 64'(bus.cdb_o[0]), 64'(prev[2]));
    chk("wrap_ready", 64'(bus.req_ready_o), 64'b1001);
    step(4'b1111, 1'b0);
    chk("wrap_ptr_ready", 64'(bus.req_ready_o), 64'b0110);
    chk("wrap_cdb0", 64'(bus.cdb_o[0]), 64'(prev[3]));
    chk("wrap_cdb1", 64'(bus.cdb_o[1]), 64'(prev[0]));

    // Flush over registered beats.
    step(4'b0011, 1'b1);
    chk("flush_ready", 64'(bus.req_ready_o), 64'b0000);
    chk("preflush_cdb_valid", 64'(bus.cdb_valid_o), 64'b11);
    chk("preflush_cnt", 64'(cnt), 64'd5);
    step(4'b0000, 1'b0);
    chk("flush_cdb_valid", 64'(bus.cdb_valid_o), 64'b00);
    chk("flush_cnt", 64'(cnt), 64'd5);
    step(4'b1111, 1'b0);
    chk("flush_ptr_ready", 64'(bus.req_ready_o), 64'b1001);
    step(4'b0000, 1'b0);
    chk("post_cnt", 64'(cnt), 64'd6);
    chk("post_cnt_sat", 64'(cnt2), 64'd3);
    chk("post_cdb_valid", 64'(bus.cdb_valid_o), 64'b11);

    // Asynchronous reset mid-cycle.
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_cdb_valid", 64'(bus.cdb_valid_o), 64'b00);
    chk("async_cdb0", 64'(bus.cdb_o[0]), 64'd0);
    chk("async_cdb1", 64'(bus.cdb_o[1]), 64'd0);
    chk("async_cnt", 64'(cnt), 64'd0);
    chk("async_cnt_sat", 64'(cnt2), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    chk("after_reset_ready", 64'(bus.req_ready_o), 64'b0011);

    // Randomised traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end
    step(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
